// File: rtl/cmp_brnch_pkg.sv
// cmp_brnch_pkg: opcode encodings shared by the instruction decoder and the compare-and-branch unit
package cmp_brnch_pkg;
  localparam logic [2:0] OP_LT  = 3'b000;
  localparam logic [2:0] OP_GT  = 3'b001;
  localparam logic [2:0] OP_EQ  = 3'b010;
  localparam logic [2:0] OP_GTE = 3'b011;
  localparam logic [2:0] OP_LTE = 3'b100;
  localparam logic [2:0] OP_NE  = 3'b101;
  localparam logic [2:0] OP_BE  = 3'b110;
  localparam logic [2:0] OP_BNE = 3'b111;
endpackage

// File: rtl/cmp_brnch_cond.sv
// cmp_brnch_cond: combinational condition bit for unsigned compares and branch-on-flag tests
module cmp_brnch_cond
  import cmp_brnch_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] R1,
  input  logic [WIDTH-1:0] R2,
  output logic             c
);
  logic w_lt;
  logic w_eq;
  logic w_nz;
  assign w_lt = R1 < R2;
  assign w_eq = R1 == R2;
  assign w_nz = |R1;
  // every relation derives from lt/eq; branch ops look at R1 alone
  always_comb begin
    c = opcode == OP_LT  ? w_lt :
        opcode == OP_GT  ? !(w_lt || w_eq) :
        opcode == OP_EQ  ? w_eq :
        opcode == OP_GTE ? !w_lt :
        opcode == OP_LTE ? (w_lt || w_eq) :
        opcode == OP_NE  ? !w_eq :
        opcode == OP_BE  ? w_nz : !w_nz;
  end
endmodule

// File: rtl/cmp_brnch.sv
// cmp_brnch: registered compare/branch condition unit producing a 0/1 result word with valid
module cmp_brnch
  import cmp_brnch_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] R1,
  input  logic [WIDTH-1:0] R2,
  output logic [WIDTH-1:0] RD,
  output logic             out_valid
);
  logic             w_c;
  logic [WIDTH-1:0] r_rd;
  logic             r_valid;
  cmp_brnch_cond #(.WIDTH(WIDTH)) u_cond (
    .opcode(opcode),
    .R1    (R1),
    .R2    (R2),
    .c     (w_c)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) r_rd <= {{(WIDTH-1){1'b0}}, w_c};
    end
  end
  assign RD        = r_rd;
  assign out_valid = r_valid;
endmodule

// File: tb/tb_cmp_brnch.sv
// tb_cmp_brnch: directed and randomized checks of cmp_brnch against an arithmetic reference model
module tb_cmp_brnch;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [2:0]   opcode = 3'd0;
  logic [W-1:0] R1 = '0;
  logic [W-1:0] R2 = '0;
  logic [W-1:0] RD;
  logic         out_valid;
  int n_checks = 0;
  int n_pass = 0;
  logic [W-1:0] exp_rd = '0;
  logic         exp_v = 1'b0;

  cmp_brnch #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode),
    .R1(R1), .R2(R2), .RD(RD), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_rd(input int op, input int unsigned a, input int unsigned b);
    bit c;
    case (op)
      0: c = a < b;
      1: c = a > b;
      2: c = a == b;
      3: c = a >= b;
      4: c = a <= b;
      5: c = a != b;
      6: c = a != 0;
      default: c = a == 0;
    endcase
    return c ? W'(1) : W'(0);
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_out(input string tag);
    check({tag, ".rd"}, RD, exp_rd);
    check({tag, ".valid"}, W'(out_valid), W'(exp_v));
  endtask

  task automatic step(input string tag, input bit v, input int op, input int unsigned a, input int unsigned b);
    @(negedge clk);
    in_valid = v;
    opcode = 3'(op);
    R1 = W'(a);
    R2 = W'(b);
    @(posedge clk);
    #1;
    if (v) exp_rd = ref_rd(op, a, b);
    exp_v = v;
    check_out(tag);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    exp_rd = '0;
    exp_v = 1'b0;
    check_out("reset");
    @(negedge clk);
    rst = 1'b0;
    step("first", 1, 0, 3, 5);
    step("lt_a", 1, 0, 5, 3);
    step("lt_b", 1, 0, 3, 3);
    step("gt_a", 1, 1, 7, 3);
    step("gt_b", 1, 1, 3, 7);
    step("gt_c", 1, 1, 7, 7);
    step("eq_a", 1, 2, 2, 2);
    step("eq_b", 1, 2, 1, 6);
    step("gte_a", 1, 3, 6, 1);
    step("gte_b", 1, 3, 4, 4);
    step("gte_c", 1, 3, 2, 4);
    step("lte_a", 1, 4, 2, 6);
    step("lte_b", 1, 4, 7, 7);
    step("lte_c", 1, 4, 7, 3);
    step("ne_a", 1, 5, 2, 6);
    step("ne_b", 1, 5, 2, 2);
    for (int i = 0; i < 3; i++) begin
      step("be_0", 1, 6, 0, $urandom_range(255));
      step("be_1", 1, 6, 1, $urandom_range(255));
      step("be_a5", 1, 6, 'hA5, $urandom_range(255));
      step("bne_1", 1, 7, 1, $urandom_range(255));
      step("bne_0", 1, 7, 0, $urandom_range(255));
    end
    step("ext_lt", 1, 0, 'h00, 'hFF);
    step("ext_gt", 1, 1, 'h80, 'h7F);
    step("ext_eq0", 1, 2, 0, 0);
    step("ext_eqff", 1, 2, 'hFF, 'hFF);
    step("ext_gteff", 1, 3, 'hFF, 'hFF);
    step("hold_eq", 1, 2, 2, 2);
    for (int i = 0; i < 3; i++)
      step("hold", 0, $urandom_range(7), $urandom_range(255), $urandom_range(255));
    step("stream_a", 1, 5, 9, 4);
    @(negedge clk);
    in_valid = 1'b1;
    opcode = 3'd2;
    R1 = 8'd7;
    R2 = 8'd7;
    #2 rst = 1'b1;
    #1;
    exp_rd = '0;
    exp_v = 1'b0;
    check_out("midrst");
    @(posedge clk);
    #1;
    check_out("midrst_edge");
    @(negedge clk);
    rst = 1'b0;
    step("resume", 1, 2, 7, 7);
    for (int i = 0; i < 60; i++)
      step("rand", ($urandom_range(3) != 0), $urandom_range(7),
           ($urandom_range(3) == 0) ? $urandom_range(3) : $urandom_range(255),
           ($urandom_range(3) == 0) ? $urandom_range(3) : $urandom_range(255));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
